// File: rtl/mips_cpu_pkg.sv
// ============================================================================
// Module   : mips_cpu_pkg
// Purpose  : Shared constants and the fetch state encoding for the MIPS CPU.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_cpu_pkg;

    localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;
    localparam logic [31:0] HALT_ADDRESS = 32'h0000_0000;
    localparam logic [31:0] PC_STEP      = 32'd4;

    typedef enum logic [1:0] {
        FETCH      = 2'd0,
        DELAY_SLOT = 2'd1,
        HALTED     = 2'd2
    } fetch_state_t;

    // Word-align a byte address by clearing its two low bits.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/mips_cpu_byteswap.sv
// ============================================================================
// Module   : mips_cpu_byteswap
// Purpose  : Reverses the four bytes of a 32-bit word (memory <-> CPU order).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_cpu_byteswap (
    input  logic [31:0] data_i,
    output logic [31:0] data_o
);

    assign data_o = {data_i[7:0], data_i[15:8], data_i[23:16], data_i[31:24]};

endmodule

`default_nettype wire

// File: rtl/mips_cpu_fetch_unit.sv
// ============================================================================
// Module   : mips_cpu_fetch_unit
// Purpose  : PC sequencing with one-slot branch delay and halt-on-zero.
//            FETCH_BYTESWAP_EN selects byte-reversed instr_word.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_cpu_fetch_unit
    import mips_cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_enable,
    input  logic        stall,
    input  logic        branch_valid,
    input  logic [31:0] branch_target,
    input  logic [31:0] instr_readdata,
    output logic [31:0] instr_address,
    output logic [31:0] instr_word,
    output logic [31:0] pc_out,
    output logic        active
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  target_q, target_d;
    logic         active_q, active_d;
    logic [31:0]  pc_inc;
    logic         advance;

    assign pc_inc  = pc_q + PC_STEP;
    assign advance = clk_enable && !stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= FETCH;
            pc_q     <= RESET_VECTOR;
            target_q <= 32'd0;
            active_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            target_q <= target_d;
            active_q <= active_d;
        end
    end

    // Any PC load that lands on HALT_ADDRESS ends execution on that same edge.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        target_d = target_q;
        active_d = active_q;
        if (advance) begin
            case (state_q)
                FETCH: begin
                    if (pc_inc == HALT_ADDRESS) begin
                        pc_d     = HALT_ADDRESS;
                        state_d  = HALTED;
                        active_d = 1'b0;
                    end else begin
                        pc_d = pc_inc;
                        if (branch_valid) begin
                            state_d  = DELAY_SLOT;
                            target_d = word_align(branch_target);
                        end
                    end
                end
                DELAY_SLOT: begin
                    if (target_q == HALT_ADDRESS) begin
                        pc_d     = HALT_ADDRESS;
                        state_d  = HALTED;
                        active_d = 1'b0;
                    end else begin
                        pc_d    = target_q;
                        state_d = FETCH;
                    end
                end
                HALTED: begin
                    pc_d     = HALT_ADDRESS;
                    active_d = 1'b0;
                end
                default: begin
                    pc_d     = HALT_ADDRESS;
                    state_d  = HALTED;
                    active_d = 1'b0;
                end
            endcase
        end
    end

    assign pc_out        = pc_q;
    assign instr_address = pc_q;
    assign active        = active_q;

`ifdef FETCH_BYTESWAP_EN
    mips_cpu_byteswap u_byteswap (
        .data_i (instr_readdata),
        .data_o (instr_word)
    );
`else
    assign instr_word = instr_readdata;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mips_cpu_fetch_unit.sv
// ============================================================================
// Module   : tb_mips_cpu_fetch_unit
// Purpose  : Directed vector bench for the fetch unit (honours FETCH_BYTESWAP_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mips_cpu_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clk_enable = 1'b1;
    logic        stall = 1'b0;
    logic        branch_valid = 1'b0;
    logic [31:0] branch_target = 32'd0;
    logic [31:0] instr_readdata = 32'd0;
    logic [31:0] instr_address;
    logic [31:0] instr_word;
    logic [31:0] pc_out;
    logic        active;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        rst;
        logic        en;
        logic        stl;
        logic        bv;
        logic [31:0] bt;
        logic [31:0] rd;
        logic [31:0] exp_pc;
        logic        exp_act;
    } vec_t;

    vec_t vecs[$];

    mips_cpu_fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .clk_enable     (clk_enable),
        .stall          (stall),
        .branch_valid   (branch_valid),
        .branch_target  (branch_target),
        .instr_readdata (instr_readdata),
        .instr_address  (instr_address),
        .instr_word     (instr_word),
        .pc_out         (pc_out),
        .active         (active)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_word(input logic [31:0] rd);
`ifdef FETCH_BYTESWAP_EN
        return {rd[7:0], rd[15:8], rd[23:16], rd[31:24]};
`else
        return rd;
`endif
    endfunction

    task automatic add(input logic rst, input logic en, input logic stl, input logic bv,
                       input logic [31:0] bt, input logic [31:0] rd,
                       input logic [31:0] exp_pc, input logic exp_act);
        vec_t v;
        v.rst = rst; v.en = en; v.stl = stl; v.bv = bv;
        v.bt = bt; v.rd = rd; v.exp_pc = exp_pc; v.exp_act = exp_act;
        vecs.push_back(v);
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    // Drive one set of inputs, take one edge, sample 1 ns later.
    task automatic step(input logic rst, input logic en, input logic stl, input logic bv,
                        input logic [31:0] bt, input logic [31:0] rd);
        reset = rst; clk_enable = en; stall = stl;
        branch_valid = bv; branch_target = bt; instr_readdata = rd;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [31:0] exp_pc,
                             input logic exp_act, input logic [31:0] rd);
        check32({tag, " pc_out"}, pc_out, exp_pc);
        check32({tag, " instr_address"}, instr_address, exp_pc);
        check1({tag, " active"}, active, exp_act);
        check32({tag, " instr_word"}, instr_word, exp_word(rd));
    endtask

    initial begin
        //   rst en stl bv  target          readdata        exp_pc          act
        add(1, 1, 0, 0, 32'h0,          32'h0100_0224, 32'hBFC0_0000, 1);
        add(0, 1, 0, 0, 32'h0,          32'h1234_5678, 32'hBFC0_0004, 1);
        add(0, 1, 0, 0, 32'h0,          32'hDEAD_BEEF, 32'hBFC0_0008, 1);
        add(0, 1, 0, 0, 32'h0,          32'h0000_00FF, 32'hBFC0_000C, 1);
        add(1, 1, 0, 0, 32'h0,          32'hA5A5_0F0F, 32'hBFC0_0000, 1);
        add(0, 1, 0, 0, 32'h0,          32'h0100_0224, 32'hBFC0_0004, 1);
        add(0, 1, 0, 0, 32'h0,          32'h0100_0224, 32'hBFC0_0008, 1);
        add(0, 1, 0, 1, 32'hBFC0_0100,  32'h1122_3344, 32'hBFC0_000C, 1);
        add(0, 1, 1, 1, 32'h0,          32'h1122_3344, 32'hBFC0_000C, 1);
        add(0, 1, 1, 0, 32'h0,          32'h1122_3344, 32'hBFC0_000C, 1);
        add(0, 1, 1, 1, 32'h0,          32'h1122_3344, 32'hBFC0_000C, 1);
        add(0, 1, 0, 1, 32'h0,          32'h5566_7788, 32'hBFC0_0100, 1);
        add(0, 1, 0, 0, 32'h0,          32'h5566_7788, 32'hBFC0_0104, 1);
        add(0, 1, 1, 1, 32'h0,          32'h0,         32'hBFC0_0104, 1);
        add(0, 1, 0, 0, 32'h0,          32'h0,         32'hBFC0_0108, 1);
        add(0, 0, 0, 1, 32'h0,          32'h0,         32'hBFC0_0108, 1);
        add(0, 0, 1, 0, 32'h0,          32'h0,         32'hBFC0_0108, 1);
        add(0, 1, 0, 0, 32'h0,          32'h0,         32'hBFC0_010C, 1);
        add(0, 1, 0, 1, 32'hBFC0_0103,  32'h0,         32'hBFC0_0110, 1);
        add(0, 1, 0, 0, 32'h0,          32'h0,         32'hBFC0_0100, 1);
        add(0, 1, 0, 1, 32'hBFC0_0203,  32'h0,         32'hBFC0_0104, 1);
        add(1, 0, 1, 0, 32'h0,          32'h0,         32'hBFC0_0000, 1);
        add(0, 1, 0, 0, 32'h0,          32'h0,         32'hBFC0_0004, 1);
        add(0, 1, 0, 0, 32'h0,          32'h0,         32'hBFC0_0008, 1);
        add(0, 1, 0, 1, 32'hFFFF_FFF8,  32'h0,         32'hBFC0_000C, 1);
        add(0, 1, 0, 0, 32'h0,          32'h0,         32'hFFFF_FFF8, 1);
        add(0, 1, 0, 0, 32'h0,          32'h0,         32'hFFFF_FFFC, 1);
        add(0, 1, 0, 0, 32'h0,          32'h0,         32'h0000_0000, 0);
        add(0, 1, 0, 1, 32'hBFC0_0100,  32'h0,         32'h0000_0000, 0);
        add(1, 1, 0, 0, 32'h0,          32'h0,         32'hBFC0_0000, 1);
        add(0, 1, 0, 0, 32'h0,          32'h0,         32'hBFC0_0004, 1);
        add(0, 1, 0, 0, 32'h0,          32'h0,         32'hBFC0_0008, 1);
        add(0, 1, 0, 1, 32'h0,          32'h0,         32'hBFC0_000C, 1);
        add(0, 1, 0, 0, 32'h0,          32'h0100_0224, 32'h0000_0000, 0);

        @(posedge clk);
        #1;
        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].en, vecs[i].stl, vecs[i].bv, vecs[i].bt, vecs[i].rd);
            check_all($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_act, vecs[i].rd);
        end

        // Halted state ignores everything but reset.
        for (int k = 0; k < 10; k++) begin
            logic [31:0] rd_r;
            rd_r = $urandom;
            step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), $urandom, rd_r);
            check_all($sformatf("halted%0d", k), 32'h0, 1'b0, rd_r);
        end

        // Unaligned target whose word address is zero also halts.
        step(1, 1, 0, 0, 32'h0, 32'h0);
        check_all("rst_after_halt", 32'hBFC0_0000, 1'b1, 32'h0);
        step(0, 1, 0, 1, 32'h0000_0003, 32'h0);
        check_all("jump3_ds", 32'hBFC0_0004, 1'b1, 32'h0);
        step(0, 1, 0, 0, 32'h0, 32'h0);
        check_all("jump3_halt", 32'h0, 1'b0, 32'h0);

        // Reset while in delay slot drops the pending target.
        step(1, 1, 0, 0, 32'h0, 32'h0);
        step(0, 1, 0, 1, 32'hBFC0_0400, 32'h0);
        check_all("ds_pre_reset", 32'hBFC0_0004, 1'b1, 32'h0);
        step(1, 1, 0, 0, 32'h0, 32'h0);
        check_all("ds_reset", 32'hBFC0_0000, 1'b1, 32'h0);
        step(0, 1, 0, 0, 32'h0, 32'h0);
        check_all("ds_dropped", 32'hBFC0_0004, 1'b1, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mips_cpu_fetch_unit.md
MIPS_CPU_FETCH_UNIT -- requirements
Module: mips_cpu_fetch_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: ports clk and reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 clk_enable  input  1  global enable; low freezes all state.
REQ-005 stall  input  1  hold current PC and instruction (downstream back-pressure).
REQ-006 branch_valid  input  1  current instruction is a taken branch or jump.
REQ-007 branch_target  input  32  byte address for that branch or jump.
REQ-008 instr_readdata  input  32  word from instruction memory, in memory byte order.
REQ-009 instr_address  output  32  word address presented to instruction memory.
REQ-010 instr_word  output  32  instruction in CPU byte order.
REQ-011 pc_out  output  32  address of the instruction on instr_word.
REQ-012 active  output  1  high while the CPU executes; low once halted.

Function
REQ-013 Memory is combinational: instr_readdata is valid in the same cycle as instr_address.
REQ-014 instr_address SHALL equal pc_out at all times.
REQ-015 The state machine SHALL have three states: FETCH, DELAY_SLOT and HALTED.
REQ-016 FETCH, branch_valid=0: on the next enabled, unstalled edge, PC <= PC+4 (modulo 2^32, wrap-around permitted).
REQ-017 FETCH, branch_valid=1: PC <= PC+4, the state SHALL go to DELAY_SLOT, and branch_target SHALL be latched with bits [1:0] forced to 0.
REQ-018 DELAY_SLOT: on the next enabled, unstalled edge, PC <= latched target and the state SHALL return to FETCH; branch_valid SHALL be ignored in this state.
REQ-019 Halt: when PC would load 0x00000000 (from either the target or the increment path), PC <= 0, the state SHALL go to HALTED, and active SHALL fall in that same edge.
REQ-020 HALTED: the state SHALL be held, PC=0, active=0, and all inputs except reset SHALL be ignored.
REQ-021 stall=1 or clk_enable=0: the PC, state, latched target and active SHALL not change; a branch_valid seen during stall SHALL have no effect.
REQ-022 clk_enable=0 together with stall SHALL behave as clk_enable=0.
REQ-023 Latency: the instruction at a new PC SHALL be available combinationally in the same cycle, giving zero added fetch latency.

Reset
REQ-024 On reset=1 at a rising edge, regardless of clk_enable or stall: PC=0xBFC00000, state=FETCH, latched target=0, active=1.
REQ-025 A reset asserted during DELAY_SLOT or HALTED SHALL discard the pending target and restart at 0xBFC00000.
REQ-026 Between power-up and the first reset edge, the outputs are undefined.

Configuration
REQ-027 The macro FETCH_BYTESWAP_EN SHALL control byte ordering of instr_word.
REQ-028 With FETCH_BYTESWAP_EN defined: instr_word = {instr_readdata[7:0], [15:8], [23:16], [31:24]}.
REQ-029 Without FETCH_BYTESWAP_EN: instr_word = instr_readdata unchanged.

Structure
REQ-030 Package mips_cpu_pkg SHALL hold RESET_VECTOR (0xBFC00000), HALT_ADDRESS (0x00000000) and the enum fetch_state_t {FETCH, DELAY_SLOT, HALTED}.
REQ-031 One sub-module, mips_cpu_byteswap, SHALL implement the 32-bit byte reversal; it SHALL be instantiated only when FETCH_BYTESWAP_EN is defined.

Verification
REQ-032 Reset then 3 free-running edges -> instr_address = 0xBFC00000, 0xBFC00004, 0xBFC00008, 0xBFC0000C; active=1 throughout.
REQ-033 branch_valid=1, target=0xBFC00100 at PC 0xBFC00008 -> next PC 0xBFC0000C (delay slot), then 0xBFC00100.
REQ-034 Jump to target 0 at PC 0xBFC00008 -> PC 0xBFC0000C, then PC 0 with active=0; 10 further edges keep PC=0 and active=0 under random inputs.
REQ-035 stall=1 for 3 edges while in DELAY_SLOT (PC 0xBFC0000C), with branch_valid toggling -> PC holds; on release, PC 0xBFC00100 with no extra branch taken.
REQ-036 Target 0xBFC00103 -> PC 0xBFC00100; reset asserted while in DELAY_SLOT -> PC 0xBFC00000 and the pending target is dropped.
REQ-037 FETCH_BYTESWAP_EN defined, instr_readdata=0x01000224 -> instr_word=0x24020001; macro undefined -> instr_word=0x01000224.
